// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: RV32M multiply/divide unit; define MULDIV_DIV_EARLY_OUT_EN for early divide-by-zero/overflow completion
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] result,
  output logic        done,
  output logic        stall
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  logic [1:0]  r_state;
  logic [2:0]  r_f3;
  logic [31:0] r_a, r_b, r_div, r_quo, r_rem;
  logic [4:0]  r_cnt;
  logic        w_sgn_in, w_sgn, w_early;
  logic [31:0] w_abs_a, w_abs_b, w_eo_res;
  logic [63:0] w_ma, w_mb, w_prod;
  logic [32:0] w_sh, w_diff;
  logic        w_qb;
  logic [31:0] w_rem_n, w_quo_n, w_q_fin, w_r_fin, w_div_res;
  // operand conditioning at accept time: DIV/REM (funct3 4,6) are signed
  always_comb begin
    w_sgn_in = ~funct3[0];
    w_abs_a  = (w_sgn_in & op_a[31]) ? -op_a : op_a;
    w_abs_b  = (w_sgn_in & op_b[31]) ? -op_b : op_b;
  end
`ifdef MULDIV_DIV_EARLY_OUT_EN
  // special divides finish straight from IDLE with their fixed results
  always_comb begin
    w_early  = funct3[2] & ((op_b == 32'd0) |
               (w_sgn_in & op_a == 32'h8000_0000 & op_b == 32'hFFFF_FFFF));
    w_eo_res = (op_b == 32'd0) ? (funct3[1] ? op_a : 32'hFFFF_FFFF)
                               : (funct3[1] ? 32'd0 : 32'h8000_0000);
  end
`else
  // special divides take the full iterative path
  always_comb begin
    w_early  = 1'b0;
    w_eo_res = 32'd0;
  end
`endif
  // 64-bit product; low 64 bits of the extended product are sign-correct
  always_comb begin
    w_ma   = {{32{r_f3 != 3'd3 & r_a[31]}}, r_a};
    w_mb   = {{32{r_f3[1] == 1'b0 & r_b[31]}}, r_b};
    w_prod = w_ma * w_mb;
  end
  // one restoring-division step plus final sign fix-up
  always_comb begin
    w_sh      = {r_rem, r_quo[31]};
    w_diff    = w_sh - {1'b0, r_div};
    w_qb      = ~w_diff[32];
    w_rem_n   = w_qb ? w_diff[31:0] : w_sh[31:0];
    w_quo_n   = {r_quo[30:0], w_qb};
    w_sgn     = ~r_f3[0];
    w_q_fin   = (w_sgn & (r_a[31] ^ r_b[31]) & (r_b != 32'd0)) ? -w_quo_n : w_quo_n;
    w_r_fin   = (w_sgn & r_a[31]) ? -w_rem_n : w_rem_n;
    w_div_res = r_f3[1] ? w_r_fin : w_q_fin;
  end
  // control FSM, operand latches and divider datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_f3    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_div   <= 32'd0;
      r_quo   <= 32'd0;
      r_rem   <= 32'd0;
      r_cnt   <= 5'd0;
      result  <= 32'd0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_f3    <= funct3;
          r_a     <= op_a;
          r_b     <= op_b;
          r_div   <= w_abs_b;
          r_quo   <= w_abs_a;
          r_rem   <= 32'd0;
          r_cnt   <= 5'd0;
          if (w_early) result <= w_eo_res;
          r_state <= w_early ? S_DONE : (funct3[2] ? S_DIV : S_MUL);
        end
        S_MUL: begin
          result  <= (r_f3 == 3'd0) ? w_prod[31:0] : w_prod[63:32];
          r_state <= S_DONE;
        end
        S_DIV: begin
          r_quo <= w_quo_n;
          r_rem <= w_rem_n;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            result  <= w_div_res;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign done  = (r_state == S_DONE);
  assign stall = (r_state == S_IDLE & start & ~flush) | r_state == S_MUL | r_state == S_DIV;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed-vector bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;
  logic        done, stall;
  int          checks = 0;
  int          failures = 0;
`ifdef MULDIV_DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif
  ex_muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .result(result), .done(done), .stall(stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input bit hold);
    int k;
    bit got;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    #1 chk({tag, "_stall_T"}, 32'(stall), 32'd1);
    k = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (!hold) start = 1'b0;
      got = done;
      if (!got && k == 1) chk({tag, "_stall_T1"}, 32'(stall), 32'd1);
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    if (hold) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk({tag, "_single_pulse"}, 32'(done), 32'd0);
    end
  endtask
  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_result", result, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    run("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 1'b0);
    run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1'b0);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0);
    run("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 1'b0);
    run("mulh_neg1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1'b0);
    run("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    run("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    run("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    run("div_5_0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, EO_LAT, 1'b0);
    run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EO_LAT, 1'b0);
    run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EO_LAT, 1'b0);
    run("divu_5_0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, EO_LAT, 1'b0);
    run("remu_5_0", 3'd7, 32'd5, 32'd0, 32'd5, EO_LAT, 1'b0);
    run("rem_-5_0", 3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, EO_LAT, 1'b0);
    @(negedge clk);
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_result_kept", result, 32'hFFFF_FFFB);
    run("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, 2, 1'b0);
    run("divu_hold", 3'd5, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    run("mul_b2b", 3'd0, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, 2, 1'b0);
    @(negedge clk);
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_result", result, 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_stall", 32'(stall), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("rstmid_no_done", 32'(seen), 32'd0);
    run("div_after_rst", 3'd4, 32'd20, 32'hFFFF_FFFB, 32'hFFFF_FFFC, 33, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
